// File: rtl/uart_pkg.sv
// Shared constants and types for the UART packet assembler.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;
    localparam logic [UART_BYTE_W-1:0] UART_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        SYNC,
        LEN,
        PAYLOAD,
        CHECK
    } pkt_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head word (no fall-through).
// A push into a full FIFO without a simultaneous pop is dropped and flagged on drop_c.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // Accept/reject decisions and next pointer/occupancy values.
    always_comb begin
        do_pop      = pop && (count != '0);
        do_push     = push && ((count != CW'(DEPTH)) || do_pop);
        drop_c      = push && !do_push;
        rd_ptr_next = rd_ptr + AW'(do_pop);
        count_next  = count + CW'(do_push) - CW'(do_pop);
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head word, forwarding a push into an empty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            valid  <= (count_next != '0);
            if (count_next != '0) begin
                head <= (do_push && (wr_ptr == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/uart_packet_assembler.sv
// Parses a framed UART byte stream (sync, word count, payload) into little-endian
// words buffered in an output FIFO. Optional macro UART_PKT_CHECKSUM_EN adds a
// trailing XOR checksum byte reported through pkt_err.
module uart_packet_assembler
    import uart_pkg::*;
#(
    parameter int unsigned              WORD_BYTES = 4,
    parameter int unsigned              FIFO_DEPTH = 8,
    parameter logic [UART_BYTE_W-1:0]   SYNC_BYTE  = UART_SYNC_BYTE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [UART_BYTE_W-1:0]            in_byte,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [UART_BYTE_W*WORD_BYTES-1:0] out_data,
    output logic                              out_last,
    output logic                              pkt_done,
    output logic                              pkt_err,
    output logic                              overflow
);

    localparam int unsigned DW  = UART_BYTE_W * WORD_BYTES;
    localparam int unsigned BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(WORD_BYTES - 1);

    pkt_state_e       state;
    pkt_state_e       state_next;
    logic [7:0]       word_num;
    logic [7:0]       word_cnt;
    logic [BCW-1:0]   byte_cnt;
    logic [DW-1:0]    asm_word;
    logic [DW-1:0]    asm_next;
    logic             word_end_c;
    logic             last_word_c;
    logic             push_c;
    logic             done_c;
    logic             err_c;
    logic             drop_c;
    logic [DW:0]      fifo_head;
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]       xor_acc;
`endif

    // Assembly word with the incoming byte dropped into its lane.
    always_comb begin
        asm_next = asm_word;
        asm_next[UART_BYTE_W*int'(byte_cnt) +: UART_BYTE_W] = in_byte;
        word_end_c  = (byte_cnt == BYTE_LAST);
        last_word_c = (word_cnt == (word_num - 8'd1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-byte control strobes.
    always_comb begin
        state_next = state;
        push_c     = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;
        case (state)
            SYNC: begin
                if (in_valid && (in_byte == SYNC_BYTE)) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (in_valid) begin
                    if (in_byte == 8'd0) begin
`ifdef UART_PKT_CHECKSUM_EN
                        state_next = CHECK;
`else
                        done_c     = 1'b1;
                        state_next = SYNC;
`endif
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (in_valid && word_end_c) begin
                    push_c = 1'b1;
                    if (last_word_c) begin
`ifdef UART_PKT_CHECKSUM_EN
                        state_next = CHECK;
`else
                        done_c     = 1'b1;
                        state_next = SYNC;
`endif
                    end
                end
            end
`ifdef UART_PKT_CHECKSUM_EN
            CHECK: begin
                if (in_valid) begin
                    done_c     = 1'b1;
                    err_c      = (in_byte != xor_acc);
                    state_next = SYNC;
                end
            end
`endif
            default: state_next = SYNC;
        endcase
    end

    // Counters, assembly register, checksum and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_num <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            overflow <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else begin
            pkt_done <= done_c;
            pkt_err  <= err_c;
            overflow <= overflow | drop_c;
            if (in_valid && (state == LEN)) begin
                word_num <= in_byte;
                word_cnt <= '0;
                byte_cnt <= '0;
`ifdef UART_PKT_CHECKSUM_EN
                xor_acc  <= in_byte;
`endif
            end
            if (in_valid && (state == PAYLOAD)) begin
                asm_word <= asm_next;
`ifdef UART_PKT_CHECKSUM_EN
                xor_acc  <= xor_acc ^ in_byte;
`endif
                if (word_end_c) begin
                    byte_cnt <= '0;
                    word_cnt <= word_cnt + 8'd1;
                end else begin
                    byte_cnt <= byte_cnt + BCW'(1);
                end
            end
        end
    end

    // Output buffer carrying the word plus its last-of-packet flag.
    uart_sync_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data ({last_word_c, asm_next}),
        .pop       (out_ready),
        .valid     (out_valid),
        .head      (fifo_head),
        .drop_c    (drop_c)
    );

    assign out_data = fifo_head[DW-1:0];
    assign out_last = fifo_head[DW];

endmodule

// File: tb/tb_uart_packet_assembler.sv
// Self-checking bench for uart_packet_assembler (default parameters).
// Builds byte streams from packet descriptions and predicts words, done pulses and errors.
module tb_uart_packet_assembler;

    typedef logic [7:0] bq_t [$];
    localparam int WB = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        pkt_done;
    logic        pkt_err;
    logic        overflow;

    int tests = 0;
    int failed = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int stall_viol = 0;
    int exp_err = 0;

    logic [32:0] exp_q [$];
    logic [32:0] got_q [$];
    logic [7:0]  stream_q [$];

    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    uart_packet_assembler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe handshakes, done pulses and stalled-head stability away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
                stall_viol++;
            if (out_valid === 1'b1 && out_ready === 1'b1)
                got_q.push_back({out_last, out_data});
            if (pkt_done === 1'b1) begin
                done_cnt++;
                if (pkt_err === 1'b1) err_cnt++;
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Reference model: append one framed packet to the stream and predict its words.
    task automatic add_packet(input int n, input bq_t pl, input bit bad);
        logic [7:0]  cs;
        logic [32:0] w;
        stream_q.push_back(8'hA5);
        stream_q.push_back(8'(n));
        cs = 8'(n);
        for (int k = 0; k < n; k++) begin
            w = '0;
            for (int j = 0; j < WB; j++) begin
                stream_q.push_back(pl[k*WB+j]);
                cs = cs ^ pl[k*WB+j];
                w  = w | (33'(pl[k*WB+j]) << (8*j));
            end
            if (k == n - 1) w[32] = 1'b1;
            exp_q.push_back(w);
        end
`ifdef UART_PKT_CHECKSUM_EN
        if (bad) begin
            cs = cs ^ 8'h5A;
            exp_err++;
        end
        stream_q.push_back(cs);
`else
        if (bad) exp_err = exp_err + 0;
`endif
    endtask

    task automatic rand_payload(input int n, output bq_t pl);
        pl = {};
        for (int i = 0; i < n * WB; i++) pl.push_back(8'($urandom));
    endtask

    // Drive the queued stream with in_valid high on consecutive cycles.
    task automatic send_stream();
        foreach (stream_q[i]) begin
            in_valid = 1'b1;
            in_byte  = stream_q[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_byte  = '0;
        stream_q.delete();
    endtask

    task automatic wait_words(input int n);
        for (int c = 0; c < 1000 && got_q.size() < n; c++) begin
            @(posedge clk); #1;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_byte = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0)  begin failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (out_data !== 32'h0)  begin failed++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        tests++; if (out_last !== 1'b0)   begin failed++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        tests++; if (pkt_done !== 1'b0)   begin failed++; $display("FAIL reset_pkt_done got=%b exp=0", pkt_done); end
        tests++; if (pkt_err !== 1'b0)    begin failed++; $display("FAIL reset_pkt_err got=%b exp=0", pkt_err); end
        tests++; if (overflow !== 1'b0)   begin failed++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bq_t pl;
        int d0 = done_cnt, e0 = err_cnt;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        got_q.delete(); exp_q.delete();
        add_packet(2, pl, 1'b0);
        exp_q = '{33'h0_44332211, 33'h1_88776655};
        send_stream();
        wait_words(exp_q.size());
        tests++; if (got_q.size() !== exp_q.size()) begin failed++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL basic_done got=%0d exp=1", done_cnt - d0); end
        tests++; if (err_cnt - e0 !== 0)  begin failed++; $display("FAIL basic_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_resync();
        bq_t pl;
        int d0 = done_cnt;
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        got_q.delete(); exp_q.delete();
        stream_q.push_back(8'h00);
        stream_q.push_back(8'hFF);
        add_packet(1, pl, 1'b0);
        exp_q = '{33'h1_EFBEADDE};
        send_stream();
        wait_words(1);
        tests++; if (got_q.size() !== 1) begin failed++; $display("FAIL resync_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            tests++; if (got_q[0] !== exp_q[0]) begin failed++; $display("FAIL resync_word got=%h exp=%h", got_q[0], exp_q[0]); end
        end
        tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL resync_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_zero_len();
        int d0 = done_cnt, e0 = err_cnt;
        got_q.delete();
        stream_q = '{8'hA5, 8'h00};
`ifdef UART_PKT_CHECKSUM_EN
        stream_q.push_back(8'h00);
`endif
        send_stream();
        repeat (4) begin @(posedge clk); #1; end
        tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL zero_done got=%0d exp=1", done_cnt - d0); end
        tests++; if (err_cnt - e0 !== 0)  begin failed++; $display("FAIL zero_err got=%0d exp=0", err_cnt - e0); end
        tests++; if (got_q.size() !== 0)  begin failed++; $display("FAIL zero_words got=%0d exp=0", got_q.size()); end
        tests++; if (out_valid !== 1'b0)  begin failed++; $display("FAIL zero_valid got=%b exp=0", out_valid); end
`ifdef UART_PKT_CHECKSUM_EN
        stream_q = '{8'hA5, 8'h00, 8'h01};
        send_stream();
        repeat (4) begin @(posedge clk); #1; end
        tests++; if (done_cnt - d0 !== 2) begin failed++; $display("FAIL zero_bad_done got=%0d exp=2", done_cnt - d0); end
        tests++; if (err_cnt - e0 !== 1)  begin failed++; $display("FAIL zero_bad_err got=%0d exp=1", err_cnt - e0); end
`endif
    endtask

    // mode 0: out_ready toggles every cycle; mode 1: out_ready random each cycle.
    task automatic test_stream(input int mode, input int npkts);
        bq_t pl;
        logic [7:0] junk;
        bit busy = 1'b1;
        int d0 = done_cnt, s0 = stall_viol;
        got_q.delete(); exp_q.delete(); exp_err = 0;
        err_cnt = 0;
        for (int p = 0; p < npkts; p++) begin
            int n = $urandom_range(1, 5);
            int nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                stream_q.push_back(junk);
            end
            rand_payload(n, pl);
            add_packet(n, pl, ($urandom_range(0, 3) == 0));
        end
        fork
            begin send_stream(); busy = 1'b0; end
            begin
                while (busy) begin
                    @(posedge clk); #1;
                    out_ready = (mode == 0) ? ~out_ready : 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_words(exp_q.size());
        tests++; if (got_q.size() !== exp_q.size()) begin failed++; $display("FAIL stream%0d_count got=%0d exp=%0d", mode, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL stream%0d_word%0d got=%h exp=%h", mode, i, got_q[i], exp_q[i]); end
        end
        tests++; if (done_cnt - d0 !== npkts) begin failed++; $display("FAIL stream%0d_done got=%0d exp=%0d", mode, done_cnt - d0, npkts); end
        tests++; if (err_cnt !== exp_err) begin failed++; $display("FAIL stream%0d_err got=%0d exp=%0d", mode, err_cnt, exp_err); end
        tests++; if (stall_viol - s0 !== 0) begin failed++; $display("FAIL stream%0d_stall_stable got=%0d exp=0", mode, stall_viol - s0); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL stream%0d_overflow got=%b exp=0", mode, overflow); end
    endtask

    task automatic test_overflow();
        bq_t pl;
        int d0 = done_cnt;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        rand_payload(10, pl);
        add_packet(10, pl, 1'b0);
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        send_stream();
        repeat (3) begin @(posedge clk); #1; end
        tests++; if (overflow !== 1'b1)  begin failed++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
        tests++; if (got_q.size() !== 0) begin failed++; $display("FAIL ovf_early got=%0d exp=0", got_q.size()); end
        out_ready = 1'b1;
        wait_words(8);
        tests++; if (got_q.size() !== 8) begin failed++; $display("FAIL ovf_count got=%0d exp=8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL ovf_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (overflow !== 1'b1)   begin failed++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL ovf_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_packet();
        bq_t pl;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        rand_payload(1, pl);
        add_packet(1, pl, 1'b0);
        stream_q.push_back(8'hA5);
        stream_q.push_back(8'h02);
        stream_q.push_back(8'h11);
        send_stream();
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        tests++; if (out_data !== 32'h0) begin failed++; $display("FAIL rstmid_data got=%h exp=0", out_data); end
        tests++; if (out_last !== 1'b0)  begin failed++; $display("FAIL rstmid_last got=%b exp=0", out_last); end
        tests++; if (pkt_done !== 1'b0)  begin failed++; $display("FAIL rstmid_done got=%b exp=0", pkt_done); end
        tests++; if (overflow !== 1'b0)  begin failed++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        add_packet(1, pl, 1'b0);
        send_stream();
        wait_words(1);
        tests++; if (got_q.size() !== 1) begin failed++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            tests++; if (got_q[0] !== 33'h1_EFBEADDE) begin failed++; $display("FAIL rstmid_word got=%h exp=1efbeadde", got_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_zero_len();
        test_stream(0, 12);
        test_overflow();
        test_reset_mid_packet();
        test_stream(1, 20);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_packet_assembler.md
Name: uart_packet_assembler

Overview:
- Sits directly downstream of the 8-bit UART receiver and consumes its single-cycle byte strobe, which has no backpressure.
- Parses a framed byte stream: sync byte, word count, then payload bytes.
- Packs payload bytes little-endian into WORD_BYTES-wide words.
- Buffers the words in a small FIFO and presents them on a valid/ready stream toward the uTPU command/load path.

Parameters:
- WORD_BYTES, 4: bytes per output word; integer ≥1.
- FIFO_DEPTH, 8: output FIFO entries; power of 2, ≥2.
- SYNC_BYTE, 8'hA5: packet start marker.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  one-cycle strobe: in_byte holds a received byte.
- in_byte  input  8  received byte.
- out_valid  output  1  FIFO head word is valid.
- out_ready  input  1  consumer accepts the head word when out_valid && out_ready.
- out_data  output  8*WORD_BYTES  head word; byte 0 in bits [7:0].
- out_last  output  1  head word is the final word of its packet.
- pkt_done  output  1  one-cycle pulse: packet fully parsed.
- pkt_err  output  1  qualified by pkt_done; checksum mismatch.
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-high) drives:
  - out_valid, out_last, pkt_done, pkt_err, overflow to 0.
  - out_data to 0.
  - FIFO to empty, state to SYNC, all counters to 0.
- Reset asserted mid-packet discards the partial word and all buffered words.
- State machine advances only on in_valid cycles:
  - SYNC: byte == SYNC_BYTE goes to LEN; any other byte is discarded and the state stays SYNC.
  - LEN: latch word count N (8 bits, 0..255). Clear byte and word counters.
    - N == 0: go to DONE path (CHECK if feature enabled, else pkt_done pulse and SYNC).
    - N > 0: go to PAYLOAD.
  - PAYLOAD: write the byte into lane byte_cnt of the assembly register.
    - When byte_cnt == WORD_BYTES-1: push the word into the FIFO, out_last = (word_cnt == N-1), and increment word_cnt.
    - After word N-1: go to CHECK (feature enabled) or SYNC with pkt_done.
- Latency: the word is pushed on the clock edge ending the final byte's in_valid cycle. out_valid is high in the next cycle; FIFO output is registered, with no fall-through.
- pkt_done is registered and pulses the cycle after the terminating byte. Without the feature, the terminating byte is the last payload byte or the LEN byte when N==0.
- FIFO rules:
  - Push when full with no simultaneous pop: word dropped, overflow set, and the state machine continues normally.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Pop when empty: ignored.
  - out_data and out_last hold steady while out_valid && !out_ready.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Fullness is tracked with an occupancy counter of log2(FIFO_DEPTH)+1 bits.
- overflow clears only on reset.
- in_valid arriving on consecutive cycles must be accepted; no byte may be lost because of internal state.

Optional Feature:
- Macro: UART_PKT_CHECKSUM_EN.
- Defined:
  - After the payload (or after LEN when N==0) the state machine enters CHECK.
  - The next byte is compared against the running XOR of the LEN byte and all payload bytes.
  - pkt_done pulses the cycle after the checksum byte, with pkt_err = mismatch; then return to SYNC.
  - Words already pushed are not retracted.
- Undefined: no CHECK state and no XOR register; pkt_err is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - UART_BYTE_W = 8.
  - Default UART_SYNC_BYTE = 8'hA5.
  - Typedef pkt_state_e {SYNC, LEN, PAYLOAD, CHECK}.
- One sub-module, uart_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Handles push/pop/full/empty and registered output.
  - The assembler instantiates it with WIDTH = 8*WORD_BYTES+1 (data plus last flag).

Test Plan:
- Basic packet: bytes A5, 02, 11, 22, 33, 44, 55, 66, 77, 88 with out_ready=1 → words 0x44332211 (last=0) then 0x88776655 (last=1); pkt_done pulses once with pkt_err=0.
- Resync: bytes 00, FF, A5, 01, DE, AD, BE, EF → exactly one word 0xEFBEADDE with last=1; no output from the junk bytes.
- Overflow: FIFO_DEPTH=8, out_ready=0, packet of N=10 → 8 words buffered and overflow=1. Then out_ready=1 → words 0..7 drained in order and overflow remains 1.
- Backpressure: out_ready toggling every cycle during a back-to-back in_valid stream → no word lost or duplicated, and out_data stable while stalled.
- Zero length: A5, 00 → pkt_done pulse, no word output. With UART_PKT_CHECKSUM_EN: A5, 00, 00 → pkt_err=0; A5, 00, 01 → pkt_err=1.
- Reset mid-packet: assert rst after A5, 02, 11 → all outputs 0 and FIFO empty. A following clean packet parses correctly.
